// File: rtl/uart_tx_sched_pkg.sv
// Shared constants and types for the uart_tx scheduler: bus addresses,
// sequencer state encoding and the tagged FIFO entry layout.
package uart_pkg;

  localparam logic [15:0] UART_ADDR_LOAD  = 16'h0111;
  localparam logic [15:0] UART_ADDR_START = 16'h0110;
  localparam logic [15:0] UART_ADDR_NOP   = 16'h0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    ACK   = 3'd4,
    GAP   = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
  } fifo_entry_t;

  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/uart_tx_sched_fifo.sv
// Small synchronous FIFO with exact occupancy count. Push while full and
// pop while empty are ignored; push and pop may coincide.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin scheduler feeding the shared uart_tx block:
// arbitrated bytes are queued with their requester tag, then sequenced out.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter logic [15:0] ADDR_LOAD  = UART_ADDR_LOAD,
  parameter logic [15:0] ADDR_START = UART_ADDR_START,
  parameter logic [15:0] ADDR_NOP   = UART_ADDR_NOP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  input  logic [7:0]             req_data0,
  input  logic [7:0]             req_data1,
  output logic [1:0]             req_ready,
  output logic [1:0]             done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            tx_addr,
  output logic [7:0]             tx_data,
  output logic                   tx_ack,
  input  logic                   tx_irq
);

  logic        rr_q, rr_d;
  logic [1:0]  grant;
  logic        push, pop;
  logic        fifo_full, fifo_empty;
  fifo_entry_t push_entry, head_entry;

  seq_state_e  state_q;
  logic        cur_id_q;
  logic [7:0]  cur_byte_q;
  logic [15:0] tx_addr_q;
  logic [7:0]  tx_data_q;
  logic        tx_ack_q;
  logic [1:0]  done_q;

  // Grant is combinational on the current count; rr only breaks ties.
  always_comb begin
    grant = 2'b00;
    if (!fifo_full) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    push_entry.id   = grant[1];
    push_entry.data = grant[1] ? req_data1 : req_data0;
  end

  assign push      = |grant;
  assign req_ready = grant;
  assign rr_d      = push ? grant[0] : rr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pop = (state_q == IDLE) && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_id_q   <= 1'b0;
      cur_byte_q <= 8'h00;
      tx_addr_q  <= ADDR_NOP;
      tx_data_q  <= 8'h00;
      tx_ack_q   <= 1'b0;
      done_q     <= 2'b00;
    end else begin
      done_q <= 2'b00;
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            cur_id_q   <= head_entry.id;
            cur_byte_q <= head_entry.data;
            tx_addr_q  <= ADDR_LOAD;
            tx_data_q  <= head_entry.data;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          tx_addr_q <= ADDR_START;
          tx_data_q <= cur_byte_q;
          state_q   <= START;
        end
        START: begin
          tx_addr_q <= ADDR_NOP;
          state_q   <= WAIT;
        end
        // irq is only honoured here; it is ignored in every other state.
        WAIT: begin
          if (tx_irq) begin
            tx_ack_q <= 1'b1;
            done_q   <= id_onehot(cur_id_q);
            state_q  <= ACK;
          end
        end
        ACK: begin
          tx_ack_q <= 1'b0;
          state_q  <= GAP;
        end
        // One idle beat so uart_tx leaves DONE before the next LOAD.
        GAP: state_q <= IDLE;
        default: begin
          tx_addr_q <= ADDR_NOP;
          tx_ack_q  <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign tx_addr = tx_addr_q;
  assign tx_data = tx_data_q;
  assign tx_ack  = tx_ack_q;
  assign done    = done_q;
  assign busy    = !fifo_empty || (state_q != IDLE);

endmodule
